// File: rtl/rom_word_seg7_scan.sv
// rom_word_seg7_scan
// Latches a 16-bit ROM word on a load strobe and shows it as four hex digits
// on a multiplexed, active-low 4-digit seven-segment display.
//
// Optional build macro: SEG7_LZB_EN
//   defined   -> leading-zero blanking of digits 3..1
//   undefined -> all four digits are always shown
//
// DIV_W sets the refresh prescaler width; each digit stays lit for
// 2^DIV_W clock cycles. DIV_W must be at least 1.

module rom_word_seg7_scan #(
    parameter int DIV_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_vld,
    input  logic        en,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  idx
);

    // Terminal count of the prescaler; reaching it means the current digit
    // slot ends on the next edge.
    localparam logic [DIV_W-1:0] PRESC_MAX = {DIV_W{1'b1}};

    // All-dark pattern for the segment bus (active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Anode pattern with every digit switched off (active-low).
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Hex digit to segment pattern, {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

    // One-hot active-low anode select for a digit index.
    function automatic logic [3:0] anode_sel(input logic [1:0] k);
        logic [3:0] sel;
        case (k)
            2'd0:    sel = 4'b1110;
            2'd1:    sel = 4'b1101;
            2'd2:    sel = 4'b1011;
            2'd3:    sel = 4'b0111;
            default: sel = AN_OFF;
        endcase
        return sel;
    endfunction

    // State registers
    logic [15:0]      data_r;
    logic [DIV_W-1:0] presc_r;
    logic [1:0]       idx_r;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;

    // Combinational helpers
    logic             tick_s;
    logic [3:0]       nib_s;
    logic             blank_s;
    logic             show_s;
    logic [3:0]       an_s;
    logic [6:0]       seg_s;
    logic             dp_s;

    assign tick_s = (presc_r == PRESC_MAX);

    // Word latch: capture din only on a load strobe, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= 16'h0000;
        end else if (din_vld) begin
            data_r <= din;
        end else begin
            data_r <= data_r;
        end
    end

    // Refresh prescaler: free-running, wraps naturally at its terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + DIV_W'(1);
        end
    end

    // Digit-scan counter: advances once per prescaler wrap, 0,1,2,3,0,...
    // It keeps running while the display is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= 2'd0;
        end else if (tick_s) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Select the nibble belonging to the currently scanned digit.
    always_comb begin
        nib_s = 4'h0;
        case (idx_r)
            2'd0:    nib_s = data_r[3:0];
            2'd1:    nib_s = data_r[7:4];
            2'd2:    nib_s = data_r[11:8];
            2'd3:    nib_s = data_r[15:12];
            default: nib_s = 4'h0;
        endcase
    end

    // Leading-zero decision: a digit is blank when it and every more
    // significant nibble are zero. Digit 0 is always shown.
    always_comb begin
        blank_s = 1'b0;
`ifdef SEG7_LZB_EN
        case (idx_r)
            2'd0:    blank_s = 1'b0;
            2'd1:    blank_s = (data_r[15:4]  == 12'h000);
            2'd2:    blank_s = (data_r[15:8]  == 8'h00);
            2'd3:    blank_s = (data_r[15:12] == 4'h0);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
    end

    // Next display pattern: either the scanned digit or fully dark.
    always_comb begin
        show_s = en & ~blank_s;
        an_s   = AN_OFF;
        seg_s  = SEG_OFF;
        dp_s   = 1'b1;
        if (show_s) begin
            an_s  = anode_sel(idx_r);
            seg_s = hex7(nib_s);
            dp_s  = ~dp_in[idx_r];
        end else begin
            an_s  = AN_OFF;
            seg_s = SEG_OFF;
            dp_s  = 1'b1;
        end
    end

    // Output stage: registering anodes and segments together keeps the
    // display glitch-free and gives a fixed one-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
            dp_r  <= dp_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;
    assign idx = idx_r;

endmodule

// File: tb/tb_rom_word_seg7_scan.sv
// Directed bench for rom_word_seg7_scan with DIV_W=2 (4-cycle digit slots).
// Expectations follow the SEG7_LZB_EN build setting.

module tb_rom_word_seg7_scan;

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        din_vld;
    logic        en;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  idx;

    int n_vec;
    int n_err;

    typedef struct {
        logic [15:0] din;
        logic        vld;
        logic        en;
        logic [3:0]  dp_in;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic [1:0]  idx;
    } vec_t;

    vec_t tbl[$];

    rom_word_seg7_scan #(.DIV_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .en      (en),
        .dp_in   (dp_in),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .idx     (idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic [15:0] d, input logic v, input logic e, input logic [3:0] dpi,
                       input logic [3:0] ean, input logic [6:0] eseg, input logic edp, input logic [1:0] eidx);
        vec_t t;
        t.din = d; t.vld = v; t.en = e; t.dp_in = dpi;
        t.an = ean; t.seg = eseg; t.dp = edp; t.idx = eidx;
        tbl.push_back(t);
    endtask

    // One full 4-cycle digit slot without a strobe; idx advances on the 4th edge.
    task automatic slot(input logic e, input logic [3:0] dpi, input logic [3:0] ean,
                        input logic [6:0] eseg, input logic edp, input logic [1:0] k);
        add(16'hDEAD, 1'b0, e, dpi, ean, eseg, edp, k);
        add(16'hDEAD, 1'b0, e, dpi, ean, eseg, edp, k);
        add(16'hDEAD, 1'b0, e, dpi, ean, eseg, edp, k);
        add(16'hDEAD, 1'b0, e, dpi, ean, eseg, edp, k + 2'd1);
    endtask

    task automatic check(input string name, input logic [3:0] ean, input logic [6:0] eseg,
                         input logic edp, input logic [1:0] eidx);
        n_vec++;
        if (an !== ean || seg !== eseg || dp !== edp || idx !== eidx) begin
            n_err++;
            $display("FAIL %s: got an=%b seg=%h dp=%b idx=%0d, want an=%b seg=%h dp=%b idx=%0d",
                     name, an, seg, dp, idx, ean, eseg, edp, eidx);
        end
    endtask

    initial begin
        logic [3:0] an_tab [4];
        logic [3:0] ean;
        logic [6:0] eseg;
        bit found;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        n_vec = 0;
        n_err = 0;

        // Vectors 1-16: blank data, plain scan; strobe 1A2F on the tick edge.
        slot(1'b1, 4'b0000, 4'b1110, 7'h40, 1'b1, 2'd0);
        slot(1'b1, 4'b0000, 4'b1101, 7'h40, 1'b1, 2'd1);
        slot(1'b1, 4'b0000, 4'b1011, 7'h40, 1'b1, 2'd2);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0000, 4'b0111, 7'h40, 1'b1, 2'd3);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0000, 4'b0111, 7'h40, 1'b1, 2'd3);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0000, 4'b0111, 7'h40, 1'b1, 2'd3);
        add(16'h1A2F, 1'b1, 1'b1, 4'b0000, 4'b0111, 7'h40, 1'b1, 2'd0);
        // Vectors 17-32: 1A2F shown as F,2,A,1.
        slot(1'b1, 4'b0000, 4'b1110, 7'h0E, 1'b1, 2'd0);
        slot(1'b1, 4'b0000, 4'b1101, 7'h24, 1'b1, 2'd1);
        slot(1'b1, 4'b0000, 4'b1011, 7'h08, 1'b1, 2'd2);
        slot(1'b1, 4'b0000, 4'b0111, 7'h79, 1'b1, 2'd3);
        // Vectors 33-36: strobe 3456 while digit 0 is lit.
        add(16'hDEAD, 1'b0, 1'b1, 4'b0000, 4'b1110, 7'h0E, 1'b1, 2'd0);
        add(16'h3456, 1'b1, 1'b1, 4'b0000, 4'b1110, 7'h0E, 1'b1, 2'd0);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0000, 4'b1110, 7'h02, 1'b1, 2'd0);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0000, 4'b1110, 7'h02, 1'b1, 2'd1);
        // Vectors 37-48: dp request on digit 2 only; strobe 0008 on tick edge.
        slot(1'b1, 4'b0100, 4'b1101, 7'h12, 1'b1, 2'd1);
        slot(1'b1, 4'b0100, 4'b1011, 7'h19, 1'b0, 2'd2);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0100, 4'b0111, 7'h30, 1'b1, 2'd3);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0100, 4'b0111, 7'h30, 1'b1, 2'd3);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0100, 4'b0111, 7'h30, 1'b1, 2'd3);
        add(16'h0008, 1'b1, 1'b1, 4'b0100, 4'b0111, 7'h30, 1'b1, 2'd0);
        // Vectors 49-64: word 0008; strobe 0100 on the last tick edge.
        slot(1'b1, 4'b0000, 4'b1110, 7'h00, 1'b1, 2'd0);
        slot(1'b1, 4'b0000, LZB ? 4'b1111 : 4'b1101, LZB ? 7'h7F : 7'h40, 1'b1, 2'd1);
        slot(1'b1, 4'b0000, LZB ? 4'b1111 : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b1, 2'd2);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0000, LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1, 2'd3);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0000, LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1, 2'd3);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0000, LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1, 2'd3);
        add(16'h0100, 1'b1, 1'b1, 4'b0000, LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1, 2'd0);
        // Vectors 65-80: word 0100; dp request on a blanked digit 3.
        slot(1'b1, 4'b0000, 4'b1110, 7'h40, 1'b1, 2'd0);
        slot(1'b1, 4'b0000, 4'b1101, 7'h40, 1'b1, 2'd1);
        slot(1'b1, 4'b0000, 4'b1011, 7'h79, 1'b1, 2'd2);
        slot(1'b1, 4'b1000, LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, LZB ? 1'b1 : 1'b0, 2'd3);
        // Vectors 81-90: display disabled for 10 cycles, scan keeps going.
        slot(1'b0, 4'b0100, 4'b1111, 7'h7F, 1'b1, 2'd0);
        slot(1'b0, 4'b0100, 4'b1111, 7'h7F, 1'b1, 2'd1);
        add(16'hDEAD, 1'b0, 1'b0, 4'b0100, 4'b1111, 7'h7F, 1'b1, 2'd2);
        add(16'hDEAD, 1'b0, 1'b0, 4'b0100, 4'b1111, 7'h7F, 1'b1, 2'd2);
        // Vectors 91-96: re-enabled mid-slot at digit 2, then digit 3.
        add(16'hDEAD, 1'b0, 1'b1, 4'b0100, 4'b1011, 7'h79, 1'b0, 2'd2);
        add(16'hDEAD, 1'b0, 1'b1, 4'b0100, 4'b1011, 7'h79, 1'b0, 2'd3);
        slot(1'b1, 4'b0000, LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1, 2'd3);

        // Asynchronous reset before any clock edge.
        rst = 1'b0; din = 16'h0000; din_vld = 1'b0; en = 1'b1; dp_in = 4'b0000;
        #2 rst = 1'b1;
        #1 check("reset_async", 4'b1111, 7'h7F, 1'b1, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            din = tbl[i].din; din_vld = tbl[i].vld; en = tbl[i].en; dp_in = tbl[i].dp_in;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i + 1), tbl[i].an, tbl[i].seg, tbl[i].dp, tbl[i].idx);
        end

        // Mid-scan reset: load 5555, wait for digit 2, reset between edges.
        din = 16'h5555; din_vld = 1'b1; en = 1'b1; dp_in = 4'b0000;
        @(posedge clk); #1;
        din_vld = 1'b0; din = 16'hDEAD;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (an == 4'b1011) found = 1'b1;
        end
        check("digit2_before_reset", 4'b1011, 7'h12, 1'b1, 2'd2);
        #3 rst = 1'b1;
        #1 check("reset_mid_scan", 4'b1111, 7'h7F, 1'b1, 2'd0);
        @(posedge clk); #1;
        check("reset_held", 4'b1111, 7'h7F, 1'b1, 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            ean  = (LZB && i >= 4) ? 4'b1111 : an_tab[i / 4];
            eseg = (LZB && i >= 4) ? 7'h7F : 7'h40;
            check($sformatf("post_reset%0d", i), ean, eseg, 1'b1, 2'((i + 1) / 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
